prescaler_ctrl: RTL and testbench

Parametrised counter-enable generator for the timer datapath. It produces a one-cycle `cnt_en` qualifier for the main timer counter. Three modes are supported:
- pass-through, when division is off
- power-of-two division, `2^div_val`
- linear division, `div_val+1`

---
 rtl/prescaler_pkg.sv | 11 +
 rtl/prescaler_limit_dec.sv | 42 ++++
 rtl/prescaler_ctrl.sv | 83 ++++++++
 tb/tb_prescaler_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/prescaler_pkg.sv
// Shared constants for the timer prescaler.
// Division-mode encodings and default widths.
package prescaler_pkg;

  localparam logic DIV_MODE_POW2 = 1'b0;
  localparam logic DIV_MODE_LIN  = 1'b1;

  localparam int CNT_W_DEF = 8;
  localparam int DIV_W_DEF = 4;

endpackage

// File: rtl/prescaler_limit_dec.sv
// Terminal-count decoder for the prescaler.
// Maps (div_en, div_mode, div_val) to a saturated limit.
module prescaler_limit_dec
  import prescaler_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             div_en,
  input  logic             div_mode,
  input  logic [DIV_W-1:0] div_val,
  output logic [CNT_W-1:0] limit
);

  localparam logic [CNT_W-1:0] ONES = '1;
  localparam int XW = (DIV_W > CNT_W) ? DIV_W : CNT_W;

  logic [XW-1:0] dv_x;

  assign dv_x = XW'(div_val);

  always_comb begin
    limit = '0;
    if (div_en) begin
      if (div_mode == DIV_MODE_POW2) begin
        if (int'(div_val) >= CNT_W) begin
          limit = '1;
        end else begin
          // 2^n - 1 as the low n bits of all-ones
          limit = ONES >> (CNT_W - int'(div_val));
        end
      end else begin
        if (dv_x > XW'(ONES)) begin
          limit = '1;
        end else begin
          limit = dv_x[CNT_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/prescaler_ctrl.sv
// Counter-enable generator for the timer datapath.
// Pass-through, power-of-two or linear division of the timer tick.
module prescaler_ctrl
  import prescaler_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             timer_en,
  input  logic             halt_req,
  input  logic             div_en,
  input  logic             div_mode,
  input  logic [DIV_W-1:0] div_val,
  output logic             cnt_en,
  output logic [CNT_W-1:0] pre_cnt,
  output logic [CNT_W-1:0] limit
);

  logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             timer_en_q;
  logic [DIV_W:0]   cfg_q;
  logic [DIV_W:0]   cfg;
  logic             cfg_change;
  logic             active;
  logic             tick;

  prescaler_limit_dec #(
    .CNT_W (CNT_W),
    .DIV_W (DIV_W)
  ) u_dec (
    .div_en   (div_en),
    .div_mode (div_mode),
    .div_val  (div_val),
    .limit    (limit)
  );

  assign cfg        = {div_mode, div_val};
  assign cfg_change = div_en & (cfg != cfg_q);
  assign active     = timer_en & div_en & ~halt_req;
  // >= rather than == so a shrunken limit can never strand the count
  assign tick       = pre_cnt_q >= limit;

  always_comb begin
    pre_cnt_d = pre_cnt_q + CNT_W'(1);
    if (timer_en_q & ~timer_en) begin
      pre_cnt_d = '0;
    end else if (~timer_en | ~div_en) begin
      pre_cnt_d = '0;
    end else if (cfg_change) begin
      pre_cnt_d = '0;
    end else if (halt_req) begin
      pre_cnt_d = pre_cnt_q;
    end else if (tick) begin
      pre_cnt_d = '0;
    end
  end

  always_comb begin
    cnt_en = 1'b0;
    if (div_en) begin
      cnt_en = active & tick & ~cfg_change;
    end else begin
      cnt_en = timer_en & ~halt_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q  <= '0;
      timer_en_q <= 1'b0;
      cfg_q      <= '0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      timer_en_q <= timer_en;
      cfg_q      <= cfg;
    end
  end

  assign pre_cnt = pre_cnt_q;

endmodule

// File: tb/tb_prescaler_ctrl.sv
// Directed scoreboard bench for prescaler_ctrl.
// Expected outputs are queued per cycle and checked at negedge.
module tb_prescaler_ctrl;

  typedef struct {
    string      tag;
    logic       en;
    logic [7:0] cnt;
    logic [7:0] lim;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       timer_en;
  logic       halt_req;
  logic       div_en;
  logic       div_mode;
  logic [3:0] div_val;
  logic       cnt_en;
  logic [7:0] pre_cnt;
  logic [7:0] limit;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  prescaler_ctrl #(
    .CNT_W (8),
    .DIV_W (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .timer_en (timer_en),
    .halt_req (halt_req),
    .div_en   (div_en),
    .div_mode (div_mode),
    .div_val  (div_val),
    .cnt_en   (cnt_en),
    .pre_cnt  (pre_cnt),
    .limit    (limit)
  );

  task automatic cyc(input string tag,
                     input logic r, input logic te,
                     input logic hr, input logic de,
                     input logic dm, input logic [3:0] dv,
                     input logic e_en, input int e_cnt,
                     input int e_lim);
    exp_t e;
    exp_t g;
    rst      = r;
    timer_en = te;
    halt_req = hr;
    div_en   = de;
    div_mode = dm;
    div_val  = dv;
    e.tag = tag;
    e.en  = e_en;
    e.cnt = 8'(e_cnt);
    e.lim = 8'(e_lim);
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    n_chk++;
    assert (cnt_en === g.en) else begin
      n_fail++;
      $error("FAIL %s cnt_en got %b want %b", g.tag, cnt_en, g.en);
    end
    n_chk++;
    assert (pre_cnt === g.cnt) else begin
      n_fail++;
      $error("FAIL %s pre_cnt got %0d want %0d", g.tag, pre_cnt, g.cnt);
    end
    n_chk++;
    assert (limit === g.lim) else begin
      n_fail++;
      $error("FAIL %s limit got %0d want %0d", g.tag, limit, g.lim);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    cyc("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // pass-through
    for (int i = 0; i < 10; i++)
      cyc("pass", 0, 1, 0, 0, 0, 0, 1, 0, 0);
    cyc("pass_halt", 0, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc("pass_halt", 0, 1, 1, 0, 0, 0, 0, 0, 0);

    // pow2 div_val=2 -> limit 3
    cyc("p2_chg", 0, 1, 0, 1, 0, 2, 0, 0, 3);
    for (int i = 0; i < 12; i++)
      cyc("p2_run", 0, 1, 0, 1, 0, 2, (i % 4) == 3, i % 4, 3);

    // pow2 div_val=0 -> every cycle
    cyc("p0_chg", 0, 1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      cyc("p0_run", 0, 1, 0, 1, 0, 0, 1, 0, 0);

    // linear div_val=5 -> period 6
    cyc("l5_chg", 0, 1, 0, 1, 1, 5, 0, 0, 5);
    for (int i = 0; i < 10; i++)
      cyc("l5_run", 0, 1, 0, 1, 1, 5, (i % 6) == 5, i % 6, 5);
    // reconfigure while pre_cnt=4
    cyc("l2_chg", 0, 1, 0, 1, 1, 2, 0, 4, 2);
    for (int i = 0; i < 9; i++)
      cyc("l2_run", 0, 1, 0, 1, 1, 2, (i % 3) == 2, i % 3, 2);

    // halt at pre_cnt=2, pow2 div_val=3
    cyc("h_chg", 0, 1, 0, 1, 0, 3, 0, 0, 7);
    cyc("h_run", 0, 1, 0, 1, 0, 3, 0, 0, 7);
    cyc("h_run", 0, 1, 0, 1, 0, 3, 0, 1, 7);
    for (int i = 0; i < 3; i++)
      cyc("h_hold", 0, 1, 1, 1, 0, 3, 0, 2, 7);
    for (int i = 2; i < 8; i++)
      cyc("h_resume", 0, 1, 0, 1, 0, 3, i == 7, i, 7);
    cyc("h_wrap", 0, 1, 0, 1, 0, 3, 0, 0, 7);

    // saturation
    cyc("s9_chg", 0, 1, 0, 1, 0, 9, 0, 1, 255);
    for (int i = 0; i < 256; i++)
      cyc("s9_run", 0, 1, 0, 1, 0, 9, i == 255, i, 255);
    cyc("s15_chg", 0, 1, 0, 1, 0, 15, 0, 0, 255);
    for (int i = 0; i < 256; i++)
      cyc("s15_run", 0, 1, 0, 1, 0, 15, i == 255, i, 255);
    cyc("l15_chg", 0, 1, 0, 1, 1, 15, 0, 0, 15);
    for (int i = 0; i < 16; i++)
      cyc("l15_run", 0, 1, 0, 1, 1, 15, i == 15, i, 15);

    // timer_en drop at pre_cnt=5
    for (int i = 0; i < 5; i++)
      cyc("d_run", 0, 1, 0, 1, 1, 15, 0, i, 15);
    cyc("d_drop", 0, 0, 0, 1, 1, 15, 0, 5, 15);
    cyc("d_off", 0, 0, 0, 1, 1, 15, 0, 0, 15);
    // timer_en low beats halt_req
    cyc("d_offh", 0, 0, 1, 1, 1, 15, 0, 0, 15);

    // reset at pre_cnt=6
    for (int i = 0; i < 6; i++)
      cyc("r_run", 0, 1, 0, 1, 1, 15, 0, i, 15);
    cyc("r_rst", 1, 1, 0, 1, 1, 15, 0, 6, 15);
    // cfg history cleared by reset, so first cycle is a change
    cyc("r_chg", 0, 1, 0, 1, 1, 15, 0, 0, 15);
    for (int i = 0; i < 4; i++)
      cyc("r_again", 0, 1, 0, 1, 1, 15, 0, i, 15);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
